inst_rom: RTL and testbench



---
 rtl/inst_rom.sv | 134 +++++++++++++
 tb/tb_inst_rom.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom.sv
// Instruction ROM for the fetch port, with a byte-serial run-time loader.
// The core sees NOPs and is held while an image is being loaded.
module inst_rom #(
   parameter int          DEPTH_LOG2 = 12,
   parameter logic [31:0] NOP_INST   = 32'h00000013
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           inst_addr_in,
   output logic [31:0]           inst_out,
   output logic                  hold_out,
   input  logic                  load_start_in,
   input  logic                  load_byte_valid_in,
   input  logic [7:0]            load_byte_in,
   output logic                  load_ready_out,
   input  logic                  load_done_in,
   output logic [DEPTH_LOG2:0]   load_word_count_out,
   output logic                  overflow_out
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_PAD  = 2'd2;

   logic [1:0]            state;
   logic [DEPTH_LOG2-1:0] wptr;
   logic [1:0]            byte_cnt;
   logic [23:0]           part;
   logic [DEPTH_LOG2:0]   count;
   logic                  ovf;
   logic [31:0]           mem [DEPTH];

   logic                  full;
   logic                  accept;
   logic [1:0]            bc_next;
   logic                  we;
   logic [31:0]           wdata;

   assign full    = (count == FULL_CNT);
   assign accept  = (state == ST_LOAD) && load_byte_valid_in
                    && !full && !load_start_in;
   assign bc_next = accept ? byte_cnt + 2'd1 : byte_cnt;

   always_comb begin
      we    = 1'b0;
      wdata = {load_byte_in, part};
      if (accept && byte_cnt == 2'd3) begin
         we = 1'b1;
      end else if (state == ST_PAD && !full && !load_start_in) begin
         we = 1'b1;
         case (byte_cnt)
            2'd1:    wdata = {24'd0, part[7:0]};
            2'd2:    wdata = {16'd0, part[15:0]};
            default: wdata = {8'd0, part[23:0]};
         endcase
      end
   end

   // Array is not reset; stale words are masked by the committed count.
   always_ff @(posedge clk) begin
      if (we)
         mem[wptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_RUN;
         wptr     <= '0;
         byte_cnt <= 2'd0;
         part     <= 24'd0;
         count    <= '0;
         ovf      <= 1'b0;
      end else if (load_start_in) begin
         state    <= ST_LOAD;
         wptr     <= '0;
         byte_cnt <= 2'd0;
         part     <= 24'd0;
         count    <= '0;
         ovf      <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (load_byte_valid_in && full)
                  ovf <= 1'b1;
               if (accept) begin
                  byte_cnt <= bc_next;
                  case (byte_cnt)
                     2'd0: part[7:0]   <= load_byte_in;
                     2'd1: part[15:8]  <= load_byte_in;
                     2'd2: part[23:16] <= load_byte_in;
                     default: begin
                        wptr  <= wptr + 1'b1;
                        count <= count + 1'b1;
                     end
                  endcase
               end
               if (load_done_in)
                  state <= (bc_next == 2'd0) ? ST_RUN : ST_PAD;
            end
            ST_PAD: begin
               if (full) begin
                  ovf <= 1'b1;
               end else begin
                  wptr  <= wptr + 1'b1;
                  count <= count + 1'b1;
               end
               byte_cnt <= 2'd0;
               state    <= ST_RUN;
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   logic [DEPTH_LOG2-1:0] widx;
   logic                  in_range;
   logic [1:0]            unused_addr_lo;

   assign widx           = inst_addr_in[DEPTH_LOG2+1:2];
   assign in_range       = (inst_addr_in[31:DEPTH_LOG2+2] == '0);
   assign unused_addr_lo = inst_addr_in[1:0];

   assign inst_out = (state == ST_RUN && in_range && {1'b0, widx} < count)
                     ? mem[widx] : NOP_INST;

   assign hold_out            = (state == ST_LOAD) || (state == ST_PAD);
   assign load_ready_out      = (state == ST_LOAD) && !full;
   assign load_word_count_out = count;
   assign overflow_out        = ovf;

endmodule

// File: tb/tb_inst_rom.sv
// Randomized bench for inst_rom: two depths driven in lockstep,
// checked against a byte-list / word-list reference model.
module tb_inst_rom;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic        start, valid, done;
   logic [7:0]  bval;

   logic [31:0] inst_b, inst_s;
   logic        hold_b, hold_s, rdy_b, rdy_s, ovf_b, ovf_s;
   logic [12:0] cnt_b;
   logic [2:0]  cnt_s;

   inst_rom u_big (
      .clk(clk), .rst(rst), .inst_addr_in(addr), .inst_out(inst_b),
      .hold_out(hold_b), .load_start_in(start),
      .load_byte_valid_in(valid), .load_byte_in(bval),
      .load_ready_out(rdy_b), .load_done_in(done),
      .load_word_count_out(cnt_b), .overflow_out(ovf_b)
   );

   inst_rom #(.DEPTH_LOG2(2)) u_small (
      .clk(clk), .rst(rst), .inst_addr_in(addr), .inst_out(inst_s),
      .hold_out(hold_s), .load_start_in(start),
      .load_byte_valid_in(valid), .load_byte_in(bval),
      .load_ready_out(rdy_s), .load_done_in(done),
      .load_word_count_out(cnt_s), .overflow_out(ovf_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // mode: 0 = running, 1 = loading, 2 = padding
   int          mmode [2];
   int          mcnt  [2];
   int          mpn   [2];
   bit          movf  [2];
   logic [7:0]  mpart [2][4];
   logic [31:0] mwords [2][4096];

   function automatic int cap(int m);
      return (m == 0) ? 4096 : 4;
   endfunction

   function automatic void model_reset();
      for (int m = 0; m < 2; m++) begin
         mmode[m] = 0; mcnt[m] = 0; mpn[m] = 0; movf[m] = 0;
      end
   endfunction

   function automatic void model_step(int m);
      logic [31:0] w;
      if (start) begin
         mmode[m] = 1; mcnt[m] = 0; mpn[m] = 0; movf[m] = 0;
         return;
      end
      if (mmode[m] == 1) begin
         if (valid) begin
            if (mcnt[m] < cap(m)) begin
               mpart[m][mpn[m]] = bval;
               mpn[m]++;
               if (mpn[m] == 4) begin
                  mwords[m][mcnt[m]] = {mpart[m][3], mpart[m][2],
                                        mpart[m][1], mpart[m][0]};
                  mcnt[m]++;
                  mpn[m] = 0;
               end
            end else begin
               movf[m] = 1;
            end
         end
         if (done)
            mmode[m] = (mpn[m] == 0) ? 0 : 2;
      end else if (mmode[m] == 2) begin
         w = 32'd0;
         for (int i = 0; i < mpn[m]; i++)
            w = w | (32'(mpart[m][i]) << (8 * i));
         if (mcnt[m] < cap(m)) begin
            mwords[m][mcnt[m]] = w;
            mcnt[m]++;
         end else begin
            movf[m] = 1;
         end
         mpn[m] = 0;
         mmode[m] = 0;
      end
   endfunction

   function automatic logic [31:0] exp_inst(int m, logic [31:0] a);
      int d;
      int w;
      d = (m == 0) ? 12 : 2;
      if (mmode[m] != 0) return NOP;
      if ((a >> (d + 2)) != 0) return NOP;
      w = int'((a >> 2) & ((32'd1 << d) - 1));
      if (w >= mcnt[m]) return NOP;
      return mwords[m][w];
   endfunction

   task automatic check_all();
      check("inst_big", inst_b, exp_inst(0, addr));
      check("inst_small", inst_s, exp_inst(1, addr));
      check("hold_big", 32'(hold_b), 32'(mmode[0] != 0));
      check("hold_small", 32'(hold_s), 32'(mmode[1] != 0));
      check("ready_big", 32'(rdy_b), 32'(mmode[0] == 1 && mcnt[0] < 4096));
      check("ready_small", 32'(rdy_s), 32'(mmode[1] == 1 && mcnt[1] < 4));
      check("count_big", 32'(cnt_b), 32'(mcnt[0]));
      check("count_small", 32'(cnt_s), 32'(mcnt[1]));
      check("ovf_big", 32'(ovf_b), 32'(movf[0]));
      check("ovf_small", 32'(ovf_s), 32'(movf[1]));
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) return 32'($urandom_range(0, 100));
      if (r == 7) return $urandom;
      return 32'h4000 | 32'($urandom_range(0, 60));
   endfunction

   task automatic step(bit s, bit v, logic [7:0] b, bit d);
      start = s; valid = v; bval = b; done = d;
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      start = 0; valid = 0; done = 0;
      addr = rand_addr();
      #1;
      check_all();
   endtask

   task automatic fetch(logic [31:0] a, logic [31:0] exp);
      addr = a;
      #1;
      check("fetch_big", inst_b, exp);
      check("fetch_small", inst_s, exp);
   endtask

   task automatic bytes(logic [7:0] b[$]);
      foreach (b[i]) step(0, 1, b[i], 0);
   endtask

   initial begin
      rst = 0; start = 0; valid = 0; done = 0; bval = 0; addr = 0;
      model_reset();
      #2;
      fetch(32'h0, NOP);
      fetch(32'h10, NOP);
      check("rst_hold", 32'(hold_b), 32'd0);
      check("rst_count", 32'(cnt_b), 32'd0);
      #8 rst = 1;

      // full-word image
      step(1, 0, 0, 0);
      bytes('{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00});
      step(0, 0, 0, 1);
      check("full_count", 32'(cnt_b), 32'd2);
      fetch(32'h0, 32'h00100513);
      fetch(32'h4, 32'h00200593);
      fetch(32'h6, 32'h00200593);
      fetch(32'h8, NOP);

      // partial trailing word with done alongside the last byte
      step(1, 0, 0, 0);
      bytes('{8'h13, 8'h05, 8'h10, 8'h00});
      step(0, 1, 8'hAB, 1);
      check("pad_hold", 32'(hold_b), 32'd1);
      step(0, 0, 0, 0);
      check("pad_hold_fall", 32'(hold_b), 32'd0);
      check("pad_count", 32'(cnt_b), 32'd2);
      fetch(32'h4, 32'h000000AB);

      // overflow on the small array
      step(1, 0, 0, 0);
      for (int i = 0; i < 17; i++) begin
         step(0, 1, 8'(i + 1), 0);
         if (i == 14) check("ovf_ready_hi", 32'(rdy_s), 32'd1);
         if (i == 15) check("ovf_ready_lo", 32'(rdy_s), 32'd0);
      end
      check("ovf_count", 32'(cnt_s), 32'd4);
      check("ovf_flag", 32'(ovf_s), 32'd1);
      step(1, 0, 0, 0);
      check("ovf_clear", 32'(ovf_s), 32'd0);
      step(0, 0, 0, 1);

      // restart in the middle of a word
      step(1, 0, 0, 0);
      bytes('{8'h11, 8'h22});
      step(1, 0, 0, 0);
      bytes('{8'h13, 8'h00, 8'h00, 8'h00});
      step(0, 0, 0, 1);
      check("restart_count", 32'(cnt_b), 32'd1);
      fetch(32'h0, NOP);

      // asynchronous reset between bytes
      step(1, 0, 0, 0);
      bytes('{8'h55, 8'h66, 8'h77, 8'h88, 8'h99});
      #3 rst = 0;
      #1;
      check("arst_hold", 32'(hold_b), 32'd0);
      check("arst_ready", 32'(rdy_b), 32'd0);
      check("arst_count", 32'(cnt_b), 32'd0);
      fetch(32'h0, NOP);
      model_reset();
      #2 rst = 1;

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7,
              8'($urandom), $urandom_range(0, 24) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
